// File: rtl/game_pkg.sv
// Shared constants for the number-match board: controller state codes,
// sum checker result codes and the BCD digit limit.
`timescale 1ns/1ps
package game_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_PLAY  = 3'd2;
  localparam logic [2:0] ST_EVAL  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [1:0] SUM_NONE = 2'b00;
  localparam logic [1:0] SUM_EQ   = 2'b01;
  localparam logic [1:0] SUM_NE   = 2'b10;
  localparam logic [1:0] WIN_CODE = SUM_EQ;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Increment a BCD digit, holding at 9 instead of wrapping.
  function automatic logic [3:0] bcd_sat_inc(input logic [3:0] v);
    return (v >= BCD_MAX) ? BCD_MAX : v + 4'd1;
  endfunction

endpackage

// File: rtl/round_ctl_tick_gen.sv
// Prescaler producing a one-cycle tick every CLK_HZ clocks; clr restarts
// the count from zero and suppresses any tick in the same cycle.
`timescale 1ns/1ps
module tick_gen #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic CLOCK,
  input  logic RESET,
  input  logic clr,
  output logic tick
);

  localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] TERM = CW'(CLK_HZ - 1);

  logic [CW-1:0] r_cnt;
  logic          w_term;

  assign w_term = (r_cnt == TERM);
  assign tick   = w_term && !clr;

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      r_cnt <= '0;
    end else if (clr || w_term) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/round_ctl.sv
// Round controller: per-round countdown, hit scoring with a one-second win
// indicator, and round/game sequencing for the 7-segment displays.
`timescale 1ns/1ps
module round_ctl #(
  parameter int         CLK_HZ     = 50_000_000,
  parameter int         ROUND_SECS = 9,
  parameter int         MAX_ROUNDS = 9,
  parameter logic [1:0] WIN_CODE   = game_pkg::WIN_CODE
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       play_en,
  input  logic       p2_load,
  input  logic [1:0] sum_status,
  output logic [3:0] time_bcd,
  output logic [3:0] score_bcd,
  output logic [3:0] round_bcd,
  output logic       new_round,
  output logic       win_led,
  output logic       game_over
);

  import game_pkg::*;

  localparam logic [3:0] LP_ROUND_SECS = 4'(ROUND_SECS);
  localparam logic [3:0] LP_MAX_ROUNDS = 4'(MAX_ROUNDS);

  logic [2:0] r_state;
  logic [2:0] w_stateNext;
  logic [2:0] w_endState;
  logic [3:0] r_time;
  logic [3:0] r_score;
  logic [3:0] r_round;
  logic [3:0] w_timeDec;
  logic       r_win;
  logic       w_hit;
  logic       w_secTick;
  logic       w_secClr;
  logic       w_winTick;

  // The countdown prescaler only runs while a round is live (PLAY and EVAL).
  assign w_secClr = !((r_state == ST_PLAY) || (r_state == ST_EVAL));

  tick_gen #(.CLK_HZ(CLK_HZ)) u_secTick (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .clr   (w_secClr),
    .tick  (w_secTick)
  );

  tick_gen #(.CLK_HZ(CLK_HZ)) u_winTick (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .clr   (w_hit),
    .tick  (w_winTick)
  );

  assign w_hit      = (r_state == ST_EVAL) && play_en && (sum_status == WIN_CODE);
  assign w_endState = (r_round >= LP_MAX_ROUNDS) ? ST_DONE : ST_START;
  assign w_timeDec  = (w_secTick && (r_time != 4'd0)) ? r_time - 4'd1 : r_time;

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_IDLE: begin
        if (play_en) w_stateNext = ST_START;
      end
      ST_START: begin
        w_stateNext = play_en ? ST_PLAY : ST_IDLE;
      end
      ST_PLAY: begin
        if (!play_en)               w_stateNext = ST_IDLE;
        else if (p2_load)           w_stateNext = ST_EVAL;
        else if (r_time == 4'd0)    w_stateNext = w_endState;
      end
      ST_EVAL: begin
        if (!play_en)                    w_stateNext = ST_IDLE;
        else if (w_hit || r_time == 4'd0) w_stateNext = w_endState;
        else                             w_stateNext = ST_PLAY;
      end
      ST_DONE: begin
        if (!play_en) w_stateNext = ST_IDLE;
      end
      default: w_stateNext = ST_IDLE;
    endcase
  end

  // Score and round survive an abort so the displays keep the last game.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      r_state <= ST_IDLE;
      r_time  <= 4'd0;
      r_score <= 4'd0;
      r_round <= 4'd0;
    end else begin
      r_state <= w_stateNext;
      case (r_state)
        ST_IDLE: begin
          if (play_en) begin
            r_score <= 4'd0;
            r_round <= 4'd0;
          end
        end
        ST_START: begin
          if (play_en) begin
            r_round <= bcd_sat_inc(r_round);
            r_time  <= LP_ROUND_SECS;
          end else begin
            r_time  <= 4'd0;
          end
        end
        ST_PLAY, ST_EVAL: begin
          r_time <= play_en ? w_timeDec : 4'd0;
        end
        default: ;
      endcase
      if (w_hit) r_score <= bcd_sat_inc(r_score);
    end
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      r_win <= 1'b0;
    end else if (w_hit) begin
      r_win <= 1'b1;
    end else if (w_winTick || ((r_state == ST_IDLE) && play_en)) begin
      r_win <= 1'b0;
    end
  end

  assign time_bcd  = r_time;
  assign score_bcd = r_score;
  assign round_bcd = r_round;
  assign new_round = (r_state == ST_START);
  assign win_led   = r_win;
  assign game_over = (r_state == ST_DONE);

endmodule

// File: tb/tb_round_ctl.sv
// Directed bench for round_ctl with a 4-cycle second, 3-second rounds and
// two rounds per game; expected values are worked out cycle by cycle.
`timescale 1ns/1ps
module tb_round_ctl;

  import game_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       playEn;
  logic       p2Load;
  logic [1:0] sumStatus;
  logic [3:0] timeBcd;
  logic [3:0] scoreBcd;
  logic [3:0] roundBcd;
  logic       newRound;
  logic       winLed;
  logic       gameOver;

  int testsRun    = 0;
  int testsFailed = 0;

  round_ctl #(
    .CLK_HZ     (4),
    .ROUND_SECS (3),
    .MAX_ROUNDS (2),
    .WIN_CODE   (2'b01)
  ) dut (
    .CLOCK      (clock),
    .RESET      (reset),
    .play_en    (playEn),
    .p2_load    (p2Load),
    .sum_status (sumStatus),
    .time_bcd   (timeBcd),
    .score_bcd  (scoreBcd),
    .round_bcd  (roundBcd),
    .new_round  (newRound),
    .win_led    (winLed),
    .game_over  (gameOver)
  );

  always #5 clock = ~clock;

  task automatic applyStimulus(input logic en, input logic load, input logic [1:0] status);
    playEn    = en;
    p2Load    = load;
    sumStatus = status;
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] observed, input logic [3:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    applyStimulus(1'b0, 1'b0, SUM_NONE);
    repeat (3) nextCycle();
    checkOutput("rst_time",     timeBcd,           4'd0);
    checkOutput("rst_score",    scoreBcd,          4'd0);
    checkOutput("rst_round",    roundBcd,          4'd0);
    checkOutput("rst_newRound", {3'b0, newRound},  4'd0);
    checkOutput("rst_win",      {3'b0, winLed},    4'd0);
    checkOutput("rst_gameOver", {3'b0, gameOver},  4'd0);
    checkOutput("rst_state",    {1'b0, dut.r_state}, 4'd0);
    reset = 1'b1;
    nextCycle();

    $display("[TB] timeout game");
    applyStimulus(1'b1, 1'b0, SUM_NONE);
    nextCycle();
    checkOutput("to_newRound1", {3'b0, newRound}, 4'd1);
    checkOutput("to_round0",    roundBcd,         4'd0);
    nextCycle();
    checkOutput("to_newRoundLow", {3'b0, newRound}, 4'd0);
    checkOutput("to_round1",    roundBcd, 4'd1);
    checkOutput("to_time3a",    timeBcd,  4'd3);
    repeat (3) nextCycle();
    checkOutput("to_time3b",    timeBcd,  4'd3);
    nextCycle();
    checkOutput("to_time2",     timeBcd,  4'd2);
    repeat (4) nextCycle();
    checkOutput("to_time1",     timeBcd,  4'd1);
    repeat (4) nextCycle();
    checkOutput("to_time0",     timeBcd,  4'd0);
    checkOutput("to_noPulse",   {3'b0, newRound}, 4'd0);
    nextCycle();
    checkOutput("to_newRound2", {3'b0, newRound}, 4'd1);
    nextCycle();
    checkOutput("to_round2",    roundBcd, 4'd2);
    checkOutput("to_r2time3",   timeBcd,  4'd3);
    repeat (12) nextCycle();
    checkOutput("to_r2time0",   timeBcd,  4'd0);
    checkOutput("to_notDone",   {3'b0, gameOver}, 4'd0);
    nextCycle();
    checkOutput("to_gameOver",  {3'b0, gameOver}, 4'd1);
    checkOutput("to_score0",    scoreBcd, 4'd0);
    checkOutput("to_doneNoPulse", {3'b0, newRound}, 4'd0);
    nextCycle();
    checkOutput("to_doneHold",  {3'b0, gameOver}, 4'd1);
    checkOutput("to_doneRound", roundBcd, 4'd2);
    applyStimulus(1'b0, 1'b0, SUM_NONE);
    nextCycle();
    checkOutput("to_idle",      {3'b0, gameOver}, 4'd0);

    $display("[TB] hit");
    applyStimulus(1'b1, 1'b0, SUM_NONE);
    nextCycle();
    checkOutput("hit_newRound", {3'b0, newRound}, 4'd1);
    nextCycle();
    checkOutput("hit_round1",   roundBcd, 4'd1);
    applyStimulus(1'b1, 1'b1, SUM_NONE);
    nextCycle();
    applyStimulus(1'b1, 1'b0, SUM_EQ);
    checkOutput("hit_scoreEarly", scoreBcd, 4'd0);
    checkOutput("hit_winEarly",   {3'b0, winLed}, 4'd0);
    nextCycle();
    checkOutput("hit_score1",   scoreBcd, 4'd1);
    checkOutput("hit_win1",     {3'b0, winLed}, 4'd1);
    checkOutput("hit_newRound2", {3'b0, newRound}, 4'd1);
    nextCycle();
    checkOutput("hit_round2",   roundBcd, 4'd2);
    checkOutput("hit_winHold",  {3'b0, winLed}, 4'd1);
    repeat (2) nextCycle();
    checkOutput("hit_winLast",  {3'b0, winLed}, 4'd1);
    nextCycle();
    checkOutput("hit_winOff",   {3'b0, winLed}, 4'd0);

    $display("[TB] abort");
    applyStimulus(1'b0, 1'b0, SUM_NONE);
    nextCycle();
    checkOutput("ab_time0",     timeBcd,  4'd0);
    checkOutput("ab_scoreHeld", scoreBcd, 4'd1);
    checkOutput("ab_roundHeld", roundBcd, 4'd2);
    checkOutput("ab_state",     {1'b0, dut.r_state}, 4'd0);
    applyStimulus(1'b1, 1'b0, SUM_NONE);
    nextCycle();
    checkOutput("ab_newRound",  {3'b0, newRound}, 4'd1);
    checkOutput("ab_scoreClr",  scoreBcd, 4'd0);
    nextCycle();
    checkOutput("ab_round1",    roundBcd, 4'd1);
    checkOutput("ab_time3",     timeBcd,  4'd3);

    $display("[TB] miss");
    repeat (4) nextCycle();
    checkOutput("miss_time2",   timeBcd, 4'd2);
    applyStimulus(1'b1, 1'b1, SUM_NE);
    nextCycle();
    applyStimulus(1'b1, 1'b0, SUM_NE);
    nextCycle();
    checkOutput("miss_score0",  scoreBcd, 4'd0);
    checkOutput("miss_win0",    {3'b0, winLed}, 4'd0);
    checkOutput("miss_play",    {1'b0, dut.r_state}, 4'd2);
    checkOutput("miss_time2b",  timeBcd, 4'd2);
    nextCycle();
    checkOutput("miss_time2c",  timeBcd, 4'd2);
    nextCycle();
    checkOutput("miss_time1",   timeBcd, 4'd1);

    $display("[TB] simultaneous tick and load");
    repeat (3) nextCycle();
    checkOutput("sim_time1",    timeBcd, 4'd1);
    applyStimulus(1'b1, 1'b1, SUM_EQ);
    nextCycle();
    applyStimulus(1'b1, 1'b0, SUM_EQ);
    checkOutput("sim_time0",    timeBcd,  4'd0);
    checkOutput("sim_scoreEarly", scoreBcd, 4'd0);
    nextCycle();
    checkOutput("sim_score1",   scoreBcd, 4'd1);
    checkOutput("sim_win1",     {3'b0, winLed}, 4'd1);
    checkOutput("sim_newRound", {3'b0, newRound}, 4'd1);
    nextCycle();
    checkOutput("sim_round2",   roundBcd, 4'd2);
    checkOutput("sim_time3",    timeBcd,  4'd3);

    $display("[TB] reset mid-play");
    nextCycle();
    #2 reset = 1'b0;
    #1;
    checkOutput("mrst_time",     timeBcd,  4'd0);
    checkOutput("mrst_score",    scoreBcd, 4'd0);
    checkOutput("mrst_round",    roundBcd, 4'd0);
    checkOutput("mrst_win",      {3'b0, winLed},   4'd0);
    checkOutput("mrst_newRound", {3'b0, newRound}, 4'd0);
    checkOutput("mrst_gameOver", {3'b0, gameOver}, 4'd0);
    checkOutput("mrst_prescale", {2'b0, dut.u_secTick.r_cnt}, 4'd0);
    #20 reset = 1'b1;

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
